// File: rtl/chirp_cfg_pkg.sv
// Shared constants and state encodings for the chirp configuration loader.
// No logic; imported by the UART receiver and the frame parser.
// Frame layout: SYNC, CMD{opcode[7:6],addr[5:0]}, DATA, CHK = CMD ^ DATA.
package chirp_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam logic [1:0] OPC_WRITE        = 2'b00;
    localparam logic [1:0] OPC_START        = 2'b01;
    localparam int         CLKS_PER_BIT_DEF = 1042;

    typedef enum logic [1:0] {
        P_IDLE,
        P_GOT_SYNC,
        P_GOT_CMD,
        P_GOT_DATA
    } parse_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_cfg_loader_if.sv
// Register-write / control strobe bundle from the config loader to chirpmod.
// Pure wiring; strobes are single-cycle, no backpressure.
// addr/data hold their value between write strobes.
interface uart_cfg_loader_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_start;
    logic                  o_err;
    logic                  o_busy;

    modport master (
        output o_wr_en, o_addr, o_data, o_start, o_err, o_busy
    );

    modport slave (
        input  o_wr_en, o_addr, o_data, o_start, o_err, o_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchroniser.
// Latency: byte_valid one cycle after the mid-stop-bit sample.
// No backpressure: byte_valid/frame_err are single-cycle pulses.
module uart_rx_byte
    import chirp_cfg_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       rx_active
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta, rx_sync, rx_prev;

    // Idle-high line: synchroniser and edge-detect flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync)
                        state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low line must not re-trigger a start until it idles.
                    if (rx_sync)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign rx_active = (state != RX_IDLE);

endmodule

// File: rtl/uart_cfg_loader.sv
// UART command-frame parser: A5,CMD,DATA,CHK -> register write / start pulse.
// Latency: strobe one cycle after CHK byte_valid; timeout after TIMEOUT_BITS bit-times idle.
// No backpressure: outputs are single-cycle strobes, malformed frames are dropped with o_err.
module uart_cfg_loader
    import chirp_cfg_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx,
    uart_cfg_loader_if.master cfg
);
    localparam int            TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW        = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_LIMIT);

    logic       byte_valid, frame_err, rx_active;
    logic [7:0] rx_byte;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .rx         (i_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .rx_active  (rx_active)
    );

    parse_state_t          pstate;
    logic [7:0]            cmd_q, data_q;
    logic [TW-1:0]         tmo_cnt;
    logic                  wr_en_q, start_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pstate  <= P_IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            tmo_cnt <= '0;
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            // frame_err and timeout share one branch so they never double-pulse o_err.
            if (frame_err || (pstate != P_IDLE && tmo_cnt == TMO_MAX)) begin
                err_q   <= 1'b1;
                pstate  <= P_IDLE;
                tmo_cnt <= '0;
            end else if (byte_valid) begin
                tmo_cnt <= '0;
                case (pstate)
                    P_IDLE: begin
                        if (rx_byte == SYNC_BYTE)
                            pstate <= P_GOT_SYNC;
                    end
                    P_GOT_SYNC: begin
                        cmd_q  <= rx_byte;
                        pstate <= P_GOT_CMD;
                    end
                    P_GOT_CMD: begin
                        data_q <= rx_byte;
                        pstate <= P_GOT_DATA;
                    end
                    P_GOT_DATA: begin
                        pstate <= P_IDLE;
                        if (rx_byte == (cmd_q ^ data_q) && cmd_q[7:6] == OPC_WRITE) begin
                            wr_en_q <= 1'b1;
                            addr_q  <= cmd_q[ADDR_WIDTH-1:0];
                            wdata_q <= data_q;
                        end else if (rx_byte == (cmd_q ^ data_q) && cmd_q[7:6] == OPC_START) begin
                            start_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: pstate <= P_IDLE;
                endcase
            end else if (pstate != P_IDLE && !rx_active) begin
                // Frozen while a byte is in flight so a slow byte is never cut.
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign cfg.o_wr_en = wr_en_q;
    assign cfg.o_addr  = addr_q;
    assign cfg.o_data  = wdata_q;
    assign cfg.o_start = start_q;
    assign cfg.o_err   = err_q;
    assign cfg.o_busy  = (pstate != P_IDLE);

endmodule

// File: tb/tb_uart_cfg_loader.sv
// Directed bench for uart_cfg_loader with a shortened bit period.
module tb_uart_cfg_loader;
    localparam int CPB   = 32;
    localparam int TBITS = 20;
    localparam int LIMIT = CPB * TBITS;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_rx    = 1'b1;

    uart_cfg_loader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) ifc ();

    uart_cfg_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (6),
        .DATA_WIDTH   (8),
        .TIMEOUT_BITS (TBITS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .cfg     (ifc)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_wr        = 0;
    int n_start     = 0;
    int n_err       = 0;
    int wr_cyc      = 0;
    logic [5:0] cap_addr = '0;
    logic [7:0] cap_data = '0;
    int t_start     = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (ifc.o_wr_en) begin
            n_wr     <= n_wr + 1;
            wr_cyc   <= cyc;
            cap_addr <= ifc.o_addr;
            cap_data <= ifc.o_data;
        end
        if (ifc.o_start) n_start <= n_start + 1;
        if (ifc.o_err)   n_err   <= n_err + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_level);
        @(posedge i_clk); #1;
        i_rx    = 1'b0;
        t_start = cyc;
        repeat (CPB) @(posedge i_clk);
        for (int i = 0; i < 8; i++) begin
            #1 i_rx = b[i];
            repeat (CPB) @(posedge i_clk);
        end
        #1 i_rx = stop_level;
        repeat (CPB) @(posedge i_clk);
        #1 i_rx = 1'b1;
        repeat (CPB) @(posedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    int w0, s0, e0;
    bit seen;

    initial begin
        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_wr_en", 32'(ifc.o_wr_en), 32'd0);
        check("rst_start", 32'(ifc.o_start), 32'd0);
        check("rst_err",   32'(ifc.o_err),   32'd0);
        check("rst_busy",  32'(ifc.o_busy),  32'd0);
        check("rst_addr",  32'(ifc.o_addr),  32'd0);
        #1 i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);

        // 1: write frame, exact strobe latency from CHK start bit
        w0 = n_wr; s0 = n_start; e0 = n_err;
        send_frame(8'hA5, 8'h05, 8'h3C, 8'h39);
        @(negedge i_clk);
        check("t1_wr_count",  32'(n_wr - w0), 32'd1);
        check("t1_addr",      32'(cap_addr), 32'h05);
        check("t1_data",      32'(cap_data), 32'h3C);
        check("t1_latency",   32'(wr_cyc - t_start), 32'(CPB/2 + 5 + 9*CPB));
        check("t1_err_count", 32'(n_err - e0), 32'd0);
        check("t1_busy",      32'(ifc.o_busy), 32'd0);

        // 2: start frame, then invalid opcode
        w0 = n_wr; s0 = n_start; e0 = n_err;
        send_frame(8'hA5, 8'h40, 8'h00, 8'h40);
        @(negedge i_clk);
        check("t2_start_count", 32'(n_start - s0), 32'd1);
        check("t2_wr_count",    32'(n_wr - w0),    32'd0);
        check("t2_addr_hold",   32'(ifc.o_addr),   32'h05);
        check("t2_data_hold",   32'(ifc.o_data),   32'h3C);
        send_frame(8'hA5, 8'hC1, 8'h00, 8'hC1);
        @(negedge i_clk);
        check("t2_badopc_err",   32'(n_err - e0),   32'd1);
        check("t2_badopc_start", 32'(n_start - s0), 32'd1);
        check("t2_badopc_wr",    32'(n_wr - w0),    32'd0);

        // 3: junk byte, bad checksum, then good frame
        w0 = n_wr; e0 = n_err;
        send_byte(8'h12, 1'b1);
        @(negedge i_clk);
        check("t3_junk_err",  32'(n_err - e0), 32'd0);
        check("t3_junk_busy", 32'(ifc.o_busy), 32'd0);
        send_frame(8'hA5, 8'h05, 8'h3C, 8'h38);
        @(negedge i_clk);
        check("t3_chk_err", 32'(n_err - e0), 32'd1);
        check("t3_chk_wr",  32'(n_wr - w0),  32'd0);
        send_frame(8'hA5, 8'h01, 8'hFF, 8'hFE);
        @(negedge i_clk);
        check("t3_wr_count", 32'(n_wr - w0), 32'd1);
        check("t3_addr",     32'(cap_addr),  32'h01);
        check("t3_data",     32'(cap_data),  32'hFF);

        // 4: framing error mid-frame, orphan bytes, short glitch
        w0 = n_wr; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        @(negedge i_clk);
        check("t4_busy_sync", 32'(ifc.o_busy), 32'd1);
        send_byte(8'h55, 1'b0);
        @(negedge i_clk);
        check("t4_ferr_err",  32'(n_err - e0), 32'd1);
        check("t4_ferr_busy", 32'(ifc.o_busy), 32'd0);
        send_byte(8'h05, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h39, 1'b1);
        @(negedge i_clk);
        check("t4_orphan_wr",  32'(n_wr - w0),  32'd0);
        check("t4_orphan_err", 32'(n_err - e0), 32'd1);
        @(posedge i_clk); #1 i_rx = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rx = 1'b1;
        repeat (3*CPB) @(posedge i_clk);
        @(negedge i_clk);
        check("t4_glitch_err",  32'(n_err - e0),  32'd1);
        check("t4_glitch_busy", 32'(ifc.o_busy),  32'd0);

        // 5: inter-byte timeout, then recovery
        w0 = n_wr; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        repeat (500) @(posedge i_clk);
        @(negedge i_clk);
        check("t5_early_err",  32'(n_err - e0), 32'd0);
        check("t5_early_busy", 32'(ifc.o_busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(negedge i_clk);
            if (n_err != e0) seen = 1'b1;
        end
        @(negedge i_clk);
        check("t5_tmo_seen",  32'(seen),        32'd1);
        check("t5_tmo_err",   32'(n_err - e0),  32'd1);
        check("t5_tmo_busy",  32'(ifc.o_busy),  32'd0);
        send_frame(8'hA5, 8'h07, 8'h10, 8'h17);
        @(negedge i_clk);
        check("t5_wr_count", 32'(n_wr - w0), 32'd1);
        check("t5_addr",     32'(cap_addr),  32'h07);
        check("t5_data",     32'(cap_data),  32'h10);

        // 6: reset mid-frame discards everything
        w0 = n_wr; s0 = n_start; e0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h3C, 1'b1);
        @(negedge i_clk);
        check("t6_busy_pre", 32'(ifc.o_busy), 32'd1);
        #1 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("t6_rst_busy", 32'(ifc.o_busy), 32'd0);
        check("t6_rst_addr", 32'(ifc.o_addr), 32'd0);
        check("t6_rst_data", 32'(ifc.o_data), 32'd0);
        #1 i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        send_byte(8'h39, 1'b1);
        @(negedge i_clk);
        check("t6_post_wr",    32'(n_wr - w0),    32'd0);
        check("t6_post_start", 32'(n_start - s0), 32'd0);
        check("t6_post_err",   32'(n_err - e0),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cfg_loader.md
Name: uart_cfg_loader

Overview:
Upstream configuration stage for the chirp generator. Receives 8N1 UART bytes on the top-level RX pin (9600 bps at 10 MHz) and parses fixed 4-byte command frames. Valid frames become single-cycle register writes or a start pulse toward chirpmod. Malformed frames, framing errors and stalled frames are flagged and discarded.

Parameters:
CLKS_PER_BIT, 1042, clock cycles per UART bit (10 MHz / 9600, rounded)
ADDR_WIDTH, 6, register address width
DATA_WIDTH, 8, register data width (fixed 8 by protocol)
TIMEOUT_BITS, 20, maximum gap between bytes of one frame, in bit-times

Ports:
i_clk  input  1  system clock, 10 MHz
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  UART RX line, asynchronous, idle high
o_wr_en  output  1  one-cycle write strobe
o_addr  output  ADDR_WIDTH  write address, valid with o_wr_en
o_data  output  DATA_WIDTH  write data, valid with o_wr_en
o_start  output  1  one-cycle start-chirp pulse
o_err  output  1  one-cycle pulse on framing, checksum, opcode or timeout error
o_busy  output  1  high while a frame is partially received

Behaviour:
- Reset: all outputs 0. Parser is in IDLE. UART is in RX_IDLE. Synchroniser flops are set to 1.
- i_rx passes through a 2-FF synchroniser. All logic uses the synchronised value.
- UART states: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a falling edge (sync 1 -> 0) enters RX_START and clears the counter.
  - RX_START: at count CLKS_PER_BIT/2 (521), sample the line. Low: go to RX_DATA. High: false start, return to RX_IDLE with no error.
  - RX_DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first.
  - RX_STOP: sample after CLKS_PER_BIT cycles. High: pulse byte_valid with byte for 1 cycle. Low: pulse frame_err, then wait for the line to return high before RX_IDLE.
- Frame format: SYNC=0xA5, CMD, DATA, CHK.
  - CMD[7:6] is the opcode: 00 = write, 01 = start, 1x = invalid.
  - CMD[5:0] is the address.
  - CHK = CMD xor DATA.
- Parser states: IDLE, GOT_SYNC, GOT_CMD, GOT_DATA.
  - IDLE: byte 0xA5 -> GOT_SYNC. Any other byte is silently ignored (resync hunting, no error).
  - GOT_SYNC: latch CMD -> GOT_CMD.
  - GOT_CMD: latch DATA -> GOT_DATA.
  - GOT_DATA: compare the received byte with CMD xor DATA, then return to IDLE.
    - Match with opcode 00: o_wr_en=1, o_addr=CMD[5:0], o_data=DATA.
    - Match with opcode 01: o_start=1.
    - Mismatch or opcode 1x: o_err=1.
- Latency: strobes fire on the cycle after byte_valid of CHK, 1 cycle long.
- o_addr and o_data hold their last value between strobes.
- o_busy = 1 in any parser state other than IDLE.
- Timeout:
  - In any state other than IDLE, a counter counts cycles since the last byte_valid.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT (20840) gives o_err=1 and a return to IDLE.
  - The counter resets on each byte_valid.
  - The counter is frozen while the UART is mid-byte, so a byte in flight is never cut.
- UART frame_err in any parser state gives o_err=1 and parser -> IDLE. In IDLE it gives o_err=1 only.
- Simultaneous events: frame_err and timeout in the same cycle produce a single o_err pulse.
- A SYNC byte received in GOT_SYNC or GOT_CMD is treated as data, not as a resync.
- Reset mid-byte or mid-frame discards everything immediately. No strobe is emitted.
- Counter widths: clog2(CLKS_PER_BIT) for the bit counter, clog2(TIMEOUT_BITS*CLKS_PER_BIT+1) for the timeout counter. No wrap is permitted.

Decomposition:
- Shared package chirp_cfg_pkg holds:
  - SYNC_BYTE, OPC_WRITE, OPC_START
  - CLKS_PER_BIT default
  - the parser state enum
  - the UART state enum
- Sub-module uart_rx_byte contains the synchroniser, UART FSM, byte_valid/frame_err/rx_active outputs and the CLKS_PER_BIT parameter.
- uart_cfg_loader instantiates uart_rx_byte and holds the parser and timeout logic.

Test Plan:
1. Write frame: send A5,05,3C,39 -> exactly one o_wr_en pulse with o_addr=0x05, o_data=0x3C, 1 cycle after CHK stop-bit sample. o_err never asserts.
2. Start frame: send A5,40,00,40 -> one o_start pulse, no o_wr_en. Also send A5,C1,00,C1 -> o_err pulse only.
3. Bad checksum plus resync: send 12,A5,05,3C,38 -> o_err pulse, no write. Then send A5,01,FF,FE -> write addr 0x01, data 0xFF.
4. Framing error and false start:
   - Byte with stop bit held low -> o_err pulse, parser back in IDLE.
   - 200-cycle low glitch on i_rx -> no byte, no error.
5. Timeout: send A5,05 then idle 20840+ cycles -> o_err pulse, o_busy falls. Then a full A5,07,10,17 frame -> write addr 0x07, data 0x10.
6. Reset mid-frame: assert i_rst_n low after A5,05,3C are received -> all outputs 0. A subsequent CHK-only byte 0x39 produces no strobe.
